// File: rtl/cic_interpolator.sv
// Three-stage CIC interpolator: low-rate samples enter through a valid/ready slot once
// every RATE clocks, pass the comb section, are zero-stuffed and integrated at full rate.
module cic_interpolator #(
  parameter int NUM_STAGES = 3,
  parameter int STG_GSZ    = 5,
  parameter int ISZ        = 16,
  parameter int OSZ        = ISZ + (NUM_STAGES - 1) * STG_GSZ
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [ISZ-1:0] in,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [OSZ-1:0] out,
  output logic           out_valid,
  output logic           underflow
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [STG_GSZ-1:0] PH_ZERO = {STG_GSZ{1'b0}};
  localparam logic [STG_GSZ-1:0] PH_ONE  = {{(STG_GSZ-1){1'b0}}, 1'b1};
  // Phase at which the first accepted sample has just reached the output register.
  localparam logic [STG_GSZ-1:0] VALID_PHASE = STG_GSZ'(2 * NUM_STAGES + 1);
  localparam logic [OSZ-1:0]     OSZ_ZERO = {OSZ{1'b0}};

  function automatic logic [OSZ-1:0] sext(input logic [ISZ-1:0] v);
    return {{(OSZ-ISZ){v[ISZ-1]}}, v};
  endfunction

  state_t             state_r, state_nxt_s;
  logic [STG_GSZ-1:0] phase_r, phase_nxt_s;
  logic               slot_s, miss_s, ready_nxt_s;
  logic [OSZ-1:0]     sample_s, stuffed_s;

  logic [OSZ-1:0]     diff_r  [0:NUM_STAGES];
  logic [OSZ-1:0]     dly_r   [1:NUM_STAGES];
  logic [NUM_STAGES:0] stb_r;
  logic [OSZ-1:0]     integ_r [0:NUM_STAGES-1];

  logic               in_ready_r, out_valid_r, underflow_r;
  logic [OSZ-1:0]     out_r;

  // Next-state, phase and slot decode
  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = phase_r;
    slot_s      = 1'b0;
    miss_s      = 1'b0;
    sample_s    = OSZ_ZERO;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          slot_s      = 1'b1;
          sample_s    = sext(in);
          state_nxt_s = ST_RUN;
          phase_nxt_s = PH_ONE;
        end else begin
          phase_nxt_s = PH_ZERO;
        end
      end
      ST_RUN: begin
        phase_nxt_s = phase_r + PH_ONE;
        if (phase_r == PH_ZERO) begin
          slot_s = 1'b1;
          // A missed slot still advances the chain, with a zero sample.
          if (in_valid) begin
            sample_s = sext(in);
          end else begin
            miss_s = 1'b1;
          end
        end else begin
          slot_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        phase_nxt_s = PH_ZERO;
      end
    endcase
    ready_nxt_s = (state_nxt_s == ST_IDLE) || (phase_nxt_s == PH_ZERO);
  end

  // Control registers: state, phase, handshake and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      phase_r     <= PH_ZERO;
      in_ready_r  <= 1'b0;
      underflow_r <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      phase_r     <= phase_nxt_s;
      in_ready_r  <= ready_nxt_s;
      underflow_r <= miss_s;
      if ((state_r == ST_RUN) && (phase_r == VALID_PHASE)) begin
        out_valid_r <= 1'b1;
      end
    end
  end

  // Comb section, one stage per strobe bit as the slot strobe walks down
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stb_r <= {(NUM_STAGES+1){1'b0}};
      for (int j = 0; j <= NUM_STAGES; j++) begin
        diff_r[j] <= OSZ_ZERO;
      end
      for (int j = 1; j <= NUM_STAGES; j++) begin
        dly_r[j] <= OSZ_ZERO;
      end
    end else begin
      stb_r <= {stb_r[NUM_STAGES-1:0], slot_s};
      if (slot_s) begin
        diff_r[0] <= sample_s;
      end
      for (int j = 1; j <= NUM_STAGES; j++) begin
        if (stb_r[j-1]) begin
          diff_r[j] <= diff_r[j-1] - dly_r[j];
          dly_r[j]  <= diff_r[j-1];
        end
      end
    end
  end

  assign stuffed_s = stb_r[NUM_STAGES] ? diff_r[NUM_STAGES] : OSZ_ZERO;

  // Integrator cascade and output register; wraps modulo 2**OSZ by design
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        integ_r[i] <= OSZ_ZERO;
      end
      out_r <= OSZ_ZERO;
    end else begin
      if (state_r == ST_RUN) begin
        integ_r[0] <= integ_r[0] + stuffed_s;
        for (int i = 1; i < NUM_STAGES; i++) begin
          integ_r[i] <= integ_r[i] + integ_r[i-1];
        end
      end
      out_r <= integ_r[NUM_STAGES-1];
    end
  end

  assign in_ready  = in_ready_r;
  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: reference is the upsampled input convolved with the
// CIC impulse response (a cube of a RATE-long boxcar), wrapped to the output width.
module tb_cic_interpolator;

  localparam int R    = 32;
  localparam int ISZ  = 16;
  localparam int OSZ  = 26;
  localparam int LAT  = 7;
  localparam int HLEN = 3 * R - 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [ISZ-1:0] din = '0;
  logic           din_valid = 1'b0;
  logic           din_ready;
  logic [OSZ-1:0] dout;
  logic           dout_valid;
  logic           dut_uf;

  always #5 clk = ~clk;

  cic_interpolator dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in        (din),
    .in_valid  (din_valid),
    .in_ready  (din_ready),
    .out       (dout),
    .out_valid (dout_valid),
    .underflow (dut_uf)
  );

  int     total = 0;
  int     bad = 0;
  longint h [HLEN];
  int     slot_e [$];
  longint slot_x [$];
  int     ecnt;
  bit     m_ready, started, exp_uf;
  int     mphase, first_e;

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, ecnt);
    end
  endtask

  function automatic longint wrap_o(input longint v);
    logic signed [OSZ-1:0] t;
    t = v[OSZ-1:0];
    return longint'(t);
  endfunction

  function automatic longint model_out();
    longint acc = 0;
    for (int j = slot_e.size() - 1; j >= 0; j--) begin
      int k = ecnt - slot_e[j] - LAT;
      if (k >= HLEN) break;
      if (k >= 0) acc += slot_x[j] * h[k];
    end
    return wrap_o(acc);
  endfunction

  task automatic model_clear();
    slot_e.delete();
    slot_x.delete();
    ecnt = 0; m_ready = 1'b0; started = 1'b0; exp_uf = 1'b0;
    mphase = 0; first_e = 0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    longint x;
    @(posedge clk);
    ecnt++;
    exp_uf = 1'b0;
    if (!started) begin
      if (m_ready && din_valid) begin
        started = 1'b1;
        first_e = ecnt;
        slot_e.push_back(ecnt);
        slot_x.push_back(longint'($signed(din)));
        mphase = 1;
      end
    end else begin
      if (mphase == 0) begin
        if (din_valid) x = longint'($signed(din));
        else begin x = 0; exp_uf = 1'b1; end
        slot_e.push_back(ecnt);
        slot_x.push_back(x);
      end
      mphase = (mphase + 1) % R;
    end
    m_ready = !started || (mphase == 0);
    @(negedge clk);
    check("out", longint'($signed(dout)), model_out());
    check("out_valid", longint'(dout_valid), longint'(started && (ecnt >= first_e + LAT)));
    check("in_ready", longint'(din_ready), longint'(m_ready));
    check("underflow", longint'(dut_uf), longint'(exp_uf));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_out", longint'(dout), 0);
    check("rst_out_valid", longint'(dout_valid), 0);
    check("rst_in_ready", longint'(din_ready), 0);
    check("rst_underflow", longint'(dut_uf), 0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int     imp_lit [5] = '{1, 3, 6, 10, 15};
    longint isum;
    int     off, cnt, n;

    for (int k = 0; k < HLEN; k++) h[k] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++)
          h[a + b + c] += 1;

    do_reset();
    step();
    check("idle_ready", longint'(din_ready), 1);

    // Impulse
    din = 16'd1; din_valid = 1'b1;
    step();
    din = 16'd0;
    isum = 0;
    for (int i = 0; i < HLEN + 16; i++) begin
      step();
      off = ecnt - first_e - LAT;
      if (off >= 0 && off < 5) check("impulse_lit", longint'($signed(dout)), imp_lit[off]);
      if (off >= 0 && off < HLEN) isum += longint'($signed(dout));
    end
    check("impulse_sum", isum, 32768);
    check("impulse_settled", longint'($signed(dout)), 0);

    // DC and handshake rate
    din = 16'd100;
    cnt = 0;
    for (int i = 0; i < 5 * R; i++) begin
      step();
      if (din_ready) cnt++;
    end
    check("dc_100", longint'($signed(dout)), 102400);
    check("ready_per_5_periods", cnt, 5);
    din = 16'h8000;
    repeat (5 * R) step();
    check("dc_neg_full_scale", longint'($signed(dout)), -33554432);

    // Single missed slot
    n = 0;
    while (!m_ready && n < 2 * R) begin step(); n++; end
    check("found_slot", longint'(m_ready), 1);
    din_valid = 1'b0;
    step();
    cnt = dut_uf ? 1 : 0;
    din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 2 * R) begin
      step(); n++;
      if (dut_uf) cnt++;
    end
    check("slot_period_after_miss", n, R - 1);
    repeat (2 * R) begin step(); if (dut_uf) cnt++; end
    check("underflow_pulses", cnt, 1);

    // Mid-run reset and restart
    do_reset();
    step();
    check("restart_ready", longint'(din_ready), 1);
    check("restart_out_valid", longint'(dout_valid), 0);

    // Random samples with random valid gaps
    for (int i = 0; i < 2000 * R; i++) begin
      din = ISZ'($urandom);
      din_valid = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
